ad_emu: RTL and testbench
=========================

AD_EMU -- requirements
Module: ad_emu

Interface
REQ-001 Parameter: NBIT, 16, bits per conversion frame shifted on sdata.
REQ-002 Parameter: SYNC, 2, synchronizer depth for cs_n/sclk into clk_sys.
REQ-003 clk_sys  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 cs_n  in  1  chip select from ad_top master, active-low, asynchronous to clk_sys.
REQ-006 sclk  in  1  serial clock from ad_top master, idle high, asynchronous to clk_sys.
REQ-007 sdata  out  1  serial sample data to master, MSB first.
REQ-008 fx_waddr  in  22  fx bus write address; [21:16] device select, [7:0] register offset.
REQ-009 fx_wr  in  1  fx bus write strobe, one clk_sys cycle.
REQ-010 fx_data  in  8  fx bus write data.
REQ-011 fx_rd  in  1  fx bus read strobe, one clk_sys cycle.
REQ-012 fx_raddr  in  22  fx bus read address, same split as fx_waddr.
REQ-013 fx_q  out  8  fx bus read data.
REQ-014 dev_id  in  6  device id compared against address [21:16].

Function
REQ-015 cs_n and sclk SHALL pass SYNC flops; edges detected on last two stages only.
REQ-016 Frame FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE->LOAD on synchronized cs_n falling edge; LOAD SHALL copy pattern word to shift register and drive sdata=bit[NBIT-1] next cycle, then enter SHIFT.
REQ-018 SHIFT: each synchronized sclk falling edge SHALL shift left one bit (zero fill) and increment bit counter.
REQ-019 SHIFT->DONE when bit counter reaches NBIT; DONE SHALL drive sdata=0 until cs_n rises.
REQ-020 Any synchronized cs_n rising edge, from any state, SHALL return FSM to IDLE, drive sdata=0, clear bit counter.
REQ-021 Frame counter (16b, wraps 0xFFFF->0x0000) SHALL increment only on SHIFT->DONE; aborted frames not counted.
REQ-022 Pattern generator SHALL advance once per completed frame, at SHIFT->DONE.
REQ-023 mode 0 FIXED: word = fix[15:0].
REQ-024 mode 1 RAMP: word += step, 16b modulo, start value fix.
REQ-025 mode 2 SQUARE: word alternates fix and ~fix+1 (two's-complement negate), toggling every per completed frames; per=0 treated as 1.
REQ-026 mode 3 SHALL behave as mode 0.
REQ-027 Write to mode or fix SHALL reload word=fix and clear square period counter next cycle; write during SHIFT SHALL NOT alter current shift register.
REQ-028 Registers (offset): 0x00 mode[1:0] RW; 0x01 fix[7:0] RW; 0x02 fix[15:8] RW; 0x03 step[7:0] RW; 0x04 step[15:8] RW; 0x05 per[7:0] RW; 0x06 frame_cnt[7:0] RO; 0x07 frame_cnt[15:8] RO; 0x08 {6'b0, state} RO.
REQ-029 Write accepted only when fx_wr=1 and fx_waddr[21:16]=dev_id; writes to RO/unmapped offsets ignored.
REQ-030 Read: fx_q registered, valid cycle after fx_rd with fx_raddr[21:16]=dev_id; else fx_q=0x00; unmapped offsets read 0x00.
REQ-031 Simultaneous cs_n fall and fx_wr to fix: LOAD SHALL use pre-write word.
REQ-032 sclk edges while IDLE or DONE SHALL be ignored.

Reset
REQ-033 rst=1 SHALL force: FSM IDLE, sdata=0, fx_q=0x00, mode=0, fix=0x0000, step=0x0001, per=0x01, word=0x0000, frame_cnt=0, bit counter 0, synchronizers to cs_n=1/sclk=1.
REQ-034 rst mid-frame SHALL abort frame without counting; after release FSM SHALL wait for a fresh cs_n falling edge.

Verification
REQ-035 mode 0, fix=0xA5C3, one 16-sclk frame -> master captures 0xA5C3, frame_cnt=1.
REQ-036 mode 1, fix=0xFFFE, step=0x0001, 3 frames -> 0xFFFE, 0xFFFF, 0x0000 (wrap).
REQ-037 mode 2, fix=0x0100, per=2, 5 frames -> 0x0100, 0x0100, 0xFF00, 0xFF00, 0x0100.
REQ-038 cs_n raised after 7 sclk -> sdata=0 within SYNC+1 cycles, frame_cnt unchanged, next frame restarts at MSB of same word.
REQ-039 Read offset 0x06 with dev_id match after 258 frames -> 0x02; offset 0x07 -> 0x01; mismatched dev_id -> 0x00.
REQ-040 rst asserted mid-SHIFT -> all REQ-033 values next cycle; sclk pulses before next cs_n fall leave sdata=0.

Source files
------------

// File: rtl/ad_emu.sv
// ad_emu: emulates a serial ADC for an external frame master.
// A cs_n/sclk framed shift register streams a pattern word MSB first
// on sdata. The pattern word (fixed, ramp or square) is set up through
// the fx register bus and advances once per completed frame.
module ad_emu #(
    parameter int NBIT = 16,
    parameter int SYNC = 2
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    output logic        sdata,
    input  logic [21:0] fx_waddr,
    input  logic        fx_wr,
    input  logic [7:0]  fx_data,
    input  logic        fx_rd,
    input  logic [21:0] fx_raddr,
    output logic [7:0]  fx_q,
    input  logic [5:0]  dev_id
);

    localparam int CW = $clog2(NBIT + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NBIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // synchronizers: index 0 is the newest sample
    logic [SYNC-1:0] cs_sync_q;
    logic [SYNC-1:0] sclk_sync_q;
    logic            cs_fall_s;
    logic            cs_rise_s;
    logic            sclk_fall_s;

    // frame engine
    state_t          state_q;
    logic [NBIT-1:0] shift_q;
    logic [CW-1:0]   bit_cnt_q;
    logic            sdata_q;
    logic            frame_done_s;

    // register file and pattern generator
    logic [1:0]  mode_q, mode_d;
    logic [15:0] fix_q, fix_d;
    logic [15:0] step_q, step_d;
    logic [7:0]  per_q, per_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  sq_cnt_q, sq_cnt_d;
    logic        sq_neg_q, sq_neg_d;
    logic [15:0] frame_cnt_q;
    logic [7:0]  fx_q_q;
    logic        wr_hit_s;
    logic        rd_hit_s;
    logic        reload_s;
    logic [7:0]  per_eff_s;
    logic        unused_addr_s;

    assign sdata = sdata_q;
    assign fx_q  = fx_q_q;
    assign unused_addr_s = ^{fx_waddr[15:8], fx_raddr[15:8]};

    // Bring cs_n and sclk into clk_sys; both idle high.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC-2:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC-2:0], sclk};
        end
    end

    // Edge detection uses only the last two synchronizer stages.
    always_comb begin
        cs_fall_s   = cs_sync_q[SYNC-1] & ~cs_sync_q[SYNC-2];
        cs_rise_s   = ~cs_sync_q[SYNC-1] & cs_sync_q[SYNC-2];
        sclk_fall_s = sclk_sync_q[SYNC-1] & ~sclk_sync_q[SYNC-2];
        if ((state_q == ST_SHIFT) && sclk_fall_s && !cs_rise_s && (bit_cnt_q == LAST_BIT)) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // Frame FSM: word is snapshotted on the IDLE->LOAD edge so a bus write
    // landing in the same cycle as the cs_n fall cannot leak into the frame.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sdata_q   <= 1'b0;
        end else if (cs_rise_s) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sdata_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sdata_q <= 1'b0;
                    if (cs_fall_s) begin
                        state_q   <= ST_LOAD;
                        shift_q   <= NBIT'(word_q);
                        bit_cnt_q <= '0;
                    end
                end
                ST_LOAD: begin
                    sdata_q <= shift_q[NBIT-1];
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_fall_s) begin
                        shift_q   <= {shift_q[NBIT-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= ST_DONE;
                            sdata_q <= 1'b0;
                        end else begin
                            sdata_q <= shift_q[NBIT-2];
                        end
                    end
                end
                ST_DONE: begin
                    sdata_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    sdata_q <= 1'b0;
                end
            endcase
        end
    end

    // Register write decode; writes to mode or fix request a pattern reload.
    always_comb begin
        wr_hit_s = fx_wr && (fx_waddr[21:16] == dev_id);
        mode_d   = mode_q;
        fix_d    = fix_q;
        step_d   = step_q;
        per_d    = per_q;
        reload_s = 1'b0;
        if (wr_hit_s) begin
            case (fx_waddr[7:0])
                8'h00: begin mode_d = fx_data[1:0]; reload_s = 1'b1; end
                8'h01: begin fix_d[7:0]  = fx_data;  reload_s = 1'b1; end
                8'h02: begin fix_d[15:8] = fx_data;  reload_s = 1'b1; end
                8'h03: step_d[7:0]  = fx_data;
                8'h04: step_d[15:8] = fx_data;
                8'h05: per_d        = fx_data;
                default: ;
            endcase
        end else begin
            reload_s = 1'b0;
        end
    end

    // Pattern next-state: a reload wins over a frame-completion advance.
    always_comb begin
        word_d    = word_q;
        sq_cnt_d  = sq_cnt_q;
        sq_neg_d  = sq_neg_q;
        per_eff_s = (per_q == 8'd0) ? 8'd1 : per_q;
        if (reload_s) begin
            word_d   = fix_d;
            sq_cnt_d = 8'd0;
            sq_neg_d = 1'b0;
        end else if (frame_done_s) begin
            case (mode_q)
                2'd1: word_d = word_q + step_q;
                2'd2: begin
                    if (({1'b0, sq_cnt_q} + 9'd1) >= {1'b0, per_eff_s}) begin
                        sq_cnt_d = 8'd0;
                        sq_neg_d = ~sq_neg_q;
                        word_d   = sq_neg_q ? fix_q : (~fix_q + 16'd1);
                    end else begin
                        sq_cnt_d = sq_cnt_q + 8'd1;
                    end
                end
                default: word_d = fix_q;
            endcase
        end else begin
            word_d = word_q;
        end
    end

    // Configuration, pattern state and frame counter registers.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            mode_q      <= 2'd0;
            fix_q       <= 16'h0000;
            step_q      <= 16'h0001;
            per_q       <= 8'h01;
            word_q      <= 16'h0000;
            sq_cnt_q    <= 8'd0;
            sq_neg_q    <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            mode_q   <= mode_d;
            fix_q    <= fix_d;
            step_q   <= step_d;
            per_q    <= per_d;
            word_q   <= word_d;
            sq_cnt_q <= sq_cnt_d;
            sq_neg_q <= sq_neg_d;
            if (frame_done_s) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    // Registered read port; returns zero whenever no matching read is pending.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fx_q_q <= 8'h00;
        end else if (rd_hit_s) begin
            case (fx_raddr[7:0])
                8'h00:   fx_q_q <= {6'b0, mode_q};
                8'h01:   fx_q_q <= fix_q[7:0];
                8'h02:   fx_q_q <= fix_q[15:8];
                8'h03:   fx_q_q <= step_q[7:0];
                8'h04:   fx_q_q <= step_q[15:8];
                8'h05:   fx_q_q <= per_q;
                8'h06:   fx_q_q <= frame_cnt_q[7:0];
                8'h07:   fx_q_q <= frame_cnt_q[15:8];
                8'h08:   fx_q_q <= {6'b0, state_q};
                default: fx_q_q <= 8'h00;
            endcase
        end else begin
            fx_q_q <= 8'h00;
        end
    end

    assign rd_hit_s = fx_rd && (fx_raddr[21:16] == dev_id);

endmodule

// File: tb/tb_ad_emu.sv
// Directed bench for ad_emu: register table plus hand-written frame sequences.
module tb_ad_emu;

    localparam int SYNC = 2;
    localparam logic [5:0] DEV   = 6'h15;
    localparam logic [5:0] OTHER = 6'h2A;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b1;
    logic        sdata;
    logic [21:0] fx_waddr = 22'd0;
    logic        fx_wr = 1'b0;
    logic [7:0]  fx_data = 8'h00;
    logic        fx_rd = 1'b0;
    logic [21:0] fx_raddr = 22'd0;
    logic [7:0]  fx_q;
    logic [5:0]  dev_id = DEV;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic       wr;
        logic [5:0] dev;
        logic [7:0] off;
        logic [7:0] data;
        logic [7:0] exp;
    } reg_vec_t;

    reg_vec_t tbl[$];

    ad_emu #(.NBIT(16), .SYNC(SYNC)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .cs_n    (cs_n),
        .sclk    (sclk),
        .sdata   (sdata),
        .fx_waddr(fx_waddr),
        .fx_wr   (fx_wr),
        .fx_data (fx_data),
        .fx_rd   (fx_rd),
        .fx_raddr(fx_raddr),
        .fx_q    (fx_q),
        .dev_id  (dev_id)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic reg_vec_t rv(input logic wr, input logic [5:0] dev, input logic [7:0] off,
                                    input logic [7:0] data, input logic [7:0] exp);
        reg_vec_t v;
        v.wr = wr; v.dev = dev; v.off = off; v.data = data; v.exp = exp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic reg_wr(input logic [5:0] dev, input logic [7:0] off, input logic [7:0] data);
        fx_waddr = {dev, 8'h00, off};
        fx_data  = data;
        fx_wr    = 1'b1;
        tick();
        fx_wr    = 1'b0;
    endtask

    task automatic reg_rd(input logic [5:0] dev, input logic [7:0] off, output logic [7:0] data);
        fx_raddr = {dev, 8'h00, off};
        fx_rd    = 1'b1;
        tick();
        fx_rd    = 1'b0;
        data     = fx_q;
    endtask

    // Master side: drop cs_n, optionally write the bus in the cycle the
    // synchronized fall is seen, then clock nbits; cs_n is left low.
    task automatic run_frame(input int nbits, input logic wr_en, input logic [7:0] wr_off,
                             input logic [7:0] wr_data, output logic [15:0] w);
        w = 16'h0000;
        cs_n = 1'b0;
        tick();
        if (wr_en) begin
            fx_waddr = {DEV, 8'h00, wr_off};
            fx_data  = wr_data;
            fx_wr    = 1'b1;
        end
        tick();
        fx_wr = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < nbits; i++) begin
            w[15-i] = sdata;
            sclk = 1'b0;
            repeat (3) tick();
            sclk = 1'b1;
            repeat (3) tick();
        end
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic full_frame(output logic [15:0] w);
        run_frame(16, 1'b0, 8'h00, 8'h00, w);
        end_frame();
    endtask

    initial begin
        logic [7:0]  rd;
        logic [15:0] w;
        logic [15:0] sq_exp [5];

        // reset state
        repeat (3) tick();
        chk("reset_sdata", {15'd0, sdata}, 16'd0);
        chk("reset_fx_q", {8'd0, fx_q}, 16'd0);
        rst = 1'b0;
        tick();

        // register access vectors
        tbl.push_back(rv(1'b0, DEV, 8'h00, 8'h00, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h01, 8'h00, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h02, 8'h00, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h03, 8'h00, 8'h01));
        tbl.push_back(rv(1'b0, DEV, 8'h04, 8'h00, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h05, 8'h00, 8'h01));
        tbl.push_back(rv(1'b0, DEV, 8'h06, 8'h00, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h07, 8'h00, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h08, 8'h00, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h09, 8'h00, 8'h00));
        tbl.push_back(rv(1'b1, DEV, 8'h03, 8'h34, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h03, 8'h00, 8'h34));
        tbl.push_back(rv(1'b1, DEV, 8'h04, 8'h12, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h04, 8'h00, 8'h12));
        tbl.push_back(rv(1'b1, DEV, 8'h05, 8'h07, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h05, 8'h00, 8'h07));
        tbl.push_back(rv(1'b1, DEV, 8'h00, 8'hFE, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h00, 8'h00, 8'h02));
        tbl.push_back(rv(1'b1, DEV, 8'h06, 8'h55, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h06, 8'h00, 8'h00));
        tbl.push_back(rv(1'b1, OTHER, 8'h01, 8'h77, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h01, 8'h00, 8'h00));
        tbl.push_back(rv(1'b0, OTHER, 8'h03, 8'h00, 8'h00));
        tbl.push_back(rv(1'b1, DEV, 8'h02, 8'hBE, 8'h00));
        tbl.push_back(rv(1'b0, DEV, 8'h02, 8'h00, 8'hBE));
        tbl.push_back(rv(1'b0, OTHER, 8'h02, 8'h00, 8'h00));
        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                reg_wr(tbl[i].dev, tbl[i].off, tbl[i].data);
            end else begin
                reg_rd(tbl[i].dev, tbl[i].off, rd);
                chk($sformatf("reg_vec%0d", i), {8'd0, rd}, {8'd0, tbl[i].exp});
            end
        end

        // mode 0 fixed word
        reg_wr(DEV, 8'h00, 8'h00);
        reg_wr(DEV, 8'h01, 8'hC3);
        reg_wr(DEV, 8'h02, 8'hA5);
        run_frame(16, 1'b0, 8'h00, 8'h00, w);
        chk("fixed_word", w, 16'hA5C3);
        chk("done_sdata", {15'd0, sdata}, 16'd0);
        reg_rd(DEV, 8'h08, rd);
        chk("state_done", {8'd0, rd}, 16'd3);
        end_frame();
        reg_rd(DEV, 8'h06, rd);
        chk("frame_cnt_1", {8'd0, rd}, 16'd1);

        // mode 1 ramp with wrap
        reg_wr(DEV, 8'h03, 8'h01);
        reg_wr(DEV, 8'h04, 8'h00);
        reg_wr(DEV, 8'h01, 8'hFE);
        reg_wr(DEV, 8'h02, 8'hFF);
        reg_wr(DEV, 8'h00, 8'h01);
        full_frame(w); chk("ramp0", w, 16'hFFFE);
        full_frame(w); chk("ramp1", w, 16'hFFFF);
        full_frame(w); chk("ramp2", w, 16'h0000);

        // mode 2 square, period 2
        sq_exp[0] = 16'h0100; sq_exp[1] = 16'h0100; sq_exp[2] = 16'hFF00;
        sq_exp[3] = 16'hFF00; sq_exp[4] = 16'h0100;
        reg_wr(DEV, 8'h01, 8'h00);
        reg_wr(DEV, 8'h02, 8'h01);
        reg_wr(DEV, 8'h05, 8'h02);
        reg_wr(DEV, 8'h00, 8'h02);
        for (int i = 0; i < 5; i++) begin
            full_frame(w);
            chk($sformatf("square%0d", i), w, sq_exp[i]);
        end

        // aborted frame after 7 sclk: no count, restart at MSB of same word
        reg_wr(DEV, 8'h01, 8'h00);
        reg_wr(DEV, 8'h02, 8'h0F);
        reg_wr(DEV, 8'h00, 8'h01);
        run_frame(7, 1'b0, 8'h00, 8'h00, w);
        chk("abort_bits", w, 16'h0E00);
        chk("abort_sdata_before", {15'd0, sdata}, 16'd1);
        cs_n = 1'b1;
        repeat (SYNC + 1) tick();
        chk("abort_sdata_after", {15'd0, sdata}, 16'd0);
        repeat (2) tick();
        reg_rd(DEV, 8'h06, rd);
        chk("abort_cnt", {8'd0, rd}, 16'd9);
        full_frame(w); chk("abort_restart", w, 16'h0F00);
        full_frame(w); chk("abort_next", w, 16'h0F01);

        // write to fix in the cycle cs_n fall is seen uses the old word
        reg_wr(DEV, 8'h00, 8'h00);
        reg_wr(DEV, 8'h01, 8'h34);
        reg_wr(DEV, 8'h02, 8'h12);
        run_frame(16, 1'b1, 8'h01, 8'h99, w);
        end_frame();
        chk("race_old_word", w, 16'h1234);
        full_frame(w); chk("race_new_word", w, 16'h1299);

        // reset during SHIFT
        run_frame(5, 1'b0, 8'h00, 8'h00, w);
        fx_raddr = {DEV, 8'h00, 8'h08};
        fx_rd = 1'b1;
        tick();
        chk("state_shift", {8'd0, fx_q}, 16'd2);
        rst = 1'b1;
        cs_n = 1'b1;
        tick();
        fx_rd = 1'b0;
        chk("rst_sdata", {15'd0, sdata}, 16'd0);
        chk("rst_fx_q", {8'd0, fx_q}, 16'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b0;
            repeat (3) tick();
            chk($sformatf("rst_sclk%0d", i), {15'd0, sdata}, 16'd0);
            sclk = 1'b1;
            repeat (3) tick();
        end
        reg_rd(DEV, 8'h08, rd); chk("rst_state", {8'd0, rd}, 16'd0);
        reg_rd(DEV, 8'h00, rd); chk("rst_mode", {8'd0, rd}, 16'd0);
        reg_rd(DEV, 8'h02, rd); chk("rst_fix_hi", {8'd0, rd}, 16'd0);
        reg_rd(DEV, 8'h03, rd); chk("rst_step_lo", {8'd0, rd}, 16'd1);
        reg_rd(DEV, 8'h05, rd); chk("rst_per", {8'd0, rd}, 16'd1);
        reg_rd(DEV, 8'h06, rd); chk("rst_cnt_lo", {8'd0, rd}, 16'd0);

        // 258 frames -> frame_cnt 0x0102
        for (int i = 0; i < 258; i++) begin
            full_frame(w);
        end
        reg_rd(DEV, 8'h06, rd);   chk("cnt258_lo", {8'd0, rd}, 16'h02);
        reg_rd(DEV, 8'h07, rd);   chk("cnt258_hi", {8'd0, rd}, 16'h01);
        reg_rd(OTHER, 8'h06, rd); chk("cnt258_other_dev", {8'd0, rd}, 16'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
